// File: rtl/blink_stretch_pkg.sv
// Shared types and width helpers for the blink_stretch LED pulse stretcher.
package blink_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // $clog2 that never returns 0, so a 1-bit counter is still declarable.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/blink_stretch_if.sv
// Event-in / LED-out bundle for blink_stretch; the ovf signal exists only with BLINK_OVF_EN.
interface blink_stretch_if #(parameter int PW = 3);
    import blink_stretch_pkg::*;

    // evt is a fire-and-forget strobe (no ready): one event per cycle it is high, never stalled.
    logic          evt;
    logic          led;
    logic          busy;
    logic [PW-1:0] pend_cnt;
    state_t        state;
`ifdef BLINK_OVF_EN
    logic          ovf;

    modport master (output evt, input led, busy, pend_cnt, state, ovf);
    modport slave  (input evt, output led, busy, pend_cnt, state, ovf);
`else
    modport master (output evt, input led, busy, pend_cnt, state);
    modport slave  (input evt, output led, busy, pend_cnt, state);
`endif

endinterface

// File: rtl/blink_stretch_ms_tick_gen.sv
// Millisecond prescaler: tick is high for the single cycle the count sits at CLK_DIV-1.
module ms_tick_gen #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/blink_stretch.sv
// Stretches 1-clk events into fixed ON/GAP LED blinks with a saturating pending queue.
// Optional BLINK_OVF_EN adds a sticky overflow flag for dropped events.
module blink_stretch
    import blink_stretch_pkg::*;
#(
    parameter int CLK_DIV  = 100000,
    parameter int ON_MS    = 50,
    parameter int OFF_MS   = 50,
    parameter int PEND_MAX = 7
) (
    input  logic           clk,
    input  logic           rst,
    blink_stretch_if.slave bus
);

    localparam int PW   = clog2_min1(PEND_MAX + 1);
    localparam int MS_W = clog2_min1(max2(ON_MS, OFF_MS));

    localparam logic [MS_W-1:0] ON_LAST  = MS_W'(ON_MS - 1);
    localparam logic [MS_W-1:0] OFF_LAST = MS_W'(OFF_MS - 1);
    localparam logic [PW-1:0]   PEND_LIM = PW'(PEND_MAX);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("blink_stretch: CLK_DIV must be >= 2");
    end
    if (ON_MS < 1 || OFF_MS < 1) begin : g_bad_ms
        $error("blink_stretch: ON_MS and OFF_MS must be >= 1");
    end
    if (PEND_MAX < 1) begin : g_bad_pend
        $error("blink_stretch: PEND_MAX must be >= 1");
    end

    state_t          state;
    logic            led_q;
    logic            busy_q;
    logic [PW-1:0]   pend_q;
    logic [MS_W-1:0] ms;
    logic            tick;
    logic            phase_end;
    logic            clr;
    logic            pend_nz;
    logic            pend_full;
    logic            accept;
    logic            deq;

    assign phase_end = tick && (((state == ON)  && (ms == ON_LAST)) ||
                                ((state == GAP) && (ms == OFF_LAST)));
    // Holding the prescaler clear in IDLE makes every ON entry start from zero.
    assign clr       = (state == IDLE) || phase_end;
    assign pend_nz   = (pend_q != '0);
    assign pend_full = (pend_q == PEND_LIM);
    // An event queues whenever it cannot start a blink by itself.
    assign accept    = bus.evt && ((state != IDLE) || pend_nz);
    assign deq       = pend_nz && ((state == IDLE) || ((state == GAP) && phase_end));

    ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

`ifdef BLINK_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            pend_q <= '0;
            ms     <= '0;
`ifdef BLINK_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            if (clr) begin
                ms <= '0;
            end else if (tick) begin
                ms <= ms + MS_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.evt || pend_nz) begin
                        state  <= ON;
                        led_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ON: begin
                    if (phase_end) begin
                        state <= GAP;
                        led_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        if (pend_nz) begin
                            state <= ON;
                            led_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    led_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase

            // Enqueue and dequeue on the same edge cancel, even when the queue is full.
            if (accept && !deq) begin
                if (!pend_full) begin
                    pend_q <= pend_q + PW'(1);
                end
`ifdef BLINK_OVF_EN
                else begin
                    ovf_q <= 1'b1;
                end
`endif
            end else if (deq && !accept) begin
                pend_q <= pend_q - PW'(1);
            end
        end
    end

    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.pend_cnt = pend_q;
    assign bus.state    = state;
`ifdef BLINK_OVF_EN
    assign bus.ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_blink_stretch.sv
// Directed bench for blink_stretch: blink start cycles go through a scoreboard queue.
module tb_blink_stretch;
  import blink_stretch_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int ON_MS    = 3;
  localparam int OFF_MS   = 2;
  localparam int PEND_MAX = 3;
  localparam int PW       = 2;
  localparam int ON_CYC   = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  blink_stretch_if #(.PW(PW)) bus ();

  blink_stretch #(
    .CLK_DIV  (CLK_DIV),
    .ON_MS    (ON_MS),
    .OFF_MS   (OFF_MS),
    .PEND_MAX (PEND_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    if (int'(cyc) > c) chk("schedule_overrun", int'(cyc), c);
    while (int'(cyc) < c) step(1);
  endtask

  // evt is sampled on edge c; on return the outputs of that edge are visible
  task automatic send(input int c);
    wait_cyc(c - 1);
    bus.evt = 1'b1;
    step(1);
    bus.evt = 1'b0;
  endtask

  // monitor: every led rise must match the head of exp_q, every blink must last ON_CYC
  logic led_d    = 1'b0;
  bit   tracking = 1'b0;
  int   rise_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      tracking = 1'b0;
      led_d    = 1'b0;
    end else begin
      if (bus.led && !led_d) begin
        rise_cyc = int'(cyc);
        tracking = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_blink: blink at cyc %0d, required none", cyc);
        end else begin
          chk("blink_start", int'(cyc), int'(exp_q.pop_front()));
        end
      end
      if (!bus.led && led_d && tracking) chk("on_length", int'(cyc) - rise_cyc, ON_CYC);
      led_d = bus.led;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required finish");
    $fatal(1, "watchdog");
  end

  int s;

  initial begin
    bus.evt = 1'b0;

    // 1. reset with evt toggling
    for (int i = 0; i < 3; i++) begin
      bus.evt = (i % 2 == 0);
      step(1);
      chk("rst_led", int'(bus.led), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_pend", int'(bus.pend_cnt), 0);
    end
    chk("rst_state", int'(bus.state), int'(IDLE));
    bus.evt = 1'b0;
    rst = 1'b1;
    step(2);

    // 2. single event
    s = int'(cyc) + 2;
    exp_q.push_back(s);
    send(s);
    chk("single_led_on", int'(bus.led), 1);
    chk("single_busy", int'(bus.busy), 1);
    wait_cyc(s + 11); chk("single_led_last", int'(bus.led), 1);
    wait_cyc(s + 12); chk("single_led_off", int'(bus.led), 0);
    chk("single_gap_busy", int'(bus.busy), 1);
    wait_cyc(s + 19); chk("single_busy_end", int'(bus.busy), 1);
    wait_cyc(s + 20); chk("single_idle", int'(bus.busy), 0);
    step(2);

    // 3. queue of three
    s = int'(cyc) + 2;
    exp_q.push_back(s);
    exp_q.push_back(s + 20);
    exp_q.push_back(s + 40);
    send(s);
    send(s + 2); chk("q_pend1", int'(bus.pend_cnt), 1);
    send(s + 5); chk("q_pend2", int'(bus.pend_cnt), 2);
    wait_cyc(s + 20); chk("q_deq1", int'(bus.pend_cnt), 1);
    wait_cyc(s + 39); chk("q_hold", int'(bus.pend_cnt), 1);
    wait_cyc(s + 40); chk("q_deq2", int'(bus.pend_cnt), 0);
    wait_cyc(s + 59); chk("q_busy_end", int'(bus.busy), 1);
    wait_cyc(s + 60); chk("q_idle", int'(bus.busy), 0);
    step(2);

    // 4. saturation
    s = int'(cyc) + 2;
    for (int i = 0; i < 4; i++) exp_q.push_back(s + 20 * i);
    send(s);
    send(s + 1);
    send(s + 2);
    send(s + 3); chk("sat_pend3", int'(bus.pend_cnt), 3);
`ifdef BLINK_OVF_EN
    chk("sat_ovf_clear", int'(bus.ovf), 0);
`endif
    send(s + 4); chk("sat_pend_hold", int'(bus.pend_cnt), 3);
`ifdef BLINK_OVF_EN
    chk("sat_ovf_set", int'(bus.ovf), 1);
`endif
    send(s + 5); chk("sat_pend_hold2", int'(bus.pend_cnt), 3);
    wait_cyc(s + 60); chk("sat_last_deq", int'(bus.pend_cnt), 0);
    wait_cyc(s + 80); chk("sat_idle", int'(bus.busy), 0);
`ifdef BLINK_OVF_EN
    chk("sat_ovf_sticky", int'(bus.ovf), 1);
`endif
    step(2);

    // 5a. evt on the GAP->ON dequeue edge
    s = int'(cyc) + 2;
    exp_q.push_back(s);
    exp_q.push_back(s + 20);
    exp_q.push_back(s + 40);
    send(s);
    send(s + 1); chk("sim_pend1", int'(bus.pend_cnt), 1);
    send(s + 20); chk("sim_pend_same", int'(bus.pend_cnt), 1);
    chk("sim_led", int'(bus.led), 1);
    wait_cyc(s + 40); chk("sim_pend0", int'(bus.pend_cnt), 0);
    wait_cyc(s + 60); chk("sim_idle", int'(bus.busy), 0);
    step(2);

    // 5b. evt on the edge IDLE is entered
    s = int'(cyc) + 2;
    exp_q.push_back(s);
    exp_q.push_back(s + 21);
    send(s);
    send(s + 20); chk("idle_q_pend", int'(bus.pend_cnt), 1);
    chk("idle_q_busy", int'(bus.busy), 0);
    step(1);
    chk("idle_q_pend0", int'(bus.pend_cnt), 0);
    chk("idle_q_busy1", int'(bus.busy), 1);
    wait_cyc(s + 41); chk("idle_q_idle", int'(bus.busy), 0);
    step(2);

    // 6. reset mid-ON with two queued
    s = int'(cyc) + 2;
    exp_q.push_back(s);
    send(s);
    send(s + 1);
    send(s + 2); chk("rmid_pend2", int'(bus.pend_cnt), 2);
    wait_cyc(s + 5);
    rst = 1'b0;
    step(1);
    chk("rmid_led", int'(bus.led), 0);
    chk("rmid_pend", int'(bus.pend_cnt), 0);
    chk("rmid_busy", int'(bus.busy), 0);
`ifdef BLINK_OVF_EN
    chk("rmid_ovf", int'(bus.ovf), 0);
`endif
    rst = 1'b1;
    step(2);
    s = int'(cyc) + 2;
    exp_q.push_back(s);
    send(s);
    wait_cyc(s + 11); chk("post_led_last", int'(bus.led), 1);
    wait_cyc(s + 12); chk("post_led_off", int'(bus.led), 0);
    wait_cyc(s + 20); chk("post_idle", int'(bus.busy), 0);
    step(3);

    // final report
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
